// File: rtl/axis_scan_raster_gen_pkg.sv
// Shared types and Q31 saturating arithmetic for the raster scan generator.
package spm_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_BWD,
    ST_NEXT_LINE,
    ST_DONE
  } scan_state_e;

  // Coordinates are signed Q31; the range is kept symmetric so that a
  // negated value always fits.
  localparam int Q_W = 32;
  localparam logic signed [Q_W-1:0] Q31_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [Q_W-1:0] Q31_MIN = -32'sh7FFF_FFFF;
  localparam logic signed [Q_W:0]   SUM_MAX = 33'sh0_7FFF_FFFF;
  localparam logic signed [Q_W:0]   SUM_MIN = -33'sh0_7FFF_FFFF;

  // a + b (or a - b when sub is set), formed at 33 bits and clamped to Q31.
  function automatic logic signed [Q_W-1:0] sat_add(
    input logic signed [Q_W-1:0] a,
    input logic signed [Q_W-1:0] b,
    input logic                  sub
  );
    logic signed [Q_W:0] sum;
    if (sub) begin
      sum = $signed({a[Q_W-1], a}) - $signed({b[Q_W-1], b});
    end else begin
      sum = $signed({a[Q_W-1], a}) + $signed({b[Q_W-1], b});
    end
    if (sum > SUM_MAX) begin
      return Q31_MAX;
    end else if (sum < SUM_MIN) begin
      return Q31_MIN;
    end else begin
      return sum[Q_W-1:0];
    end
  endfunction

endpackage

// File: rtl/axis_scan_raster_gen_if.sv
// Coordinate streams and per-point status leaving the scan generator.
interface axis_scan_raster_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NPTS_W     = 16
);
  logic signed [DATA_WIDTH-1:0] M_AXIS_Xs_tdata;
  logic                         M_AXIS_Xs_tvalid;
  logic signed [DATA_WIDTH-1:0] M_AXIS_Ys_tdata;
  logic                         M_AXIS_Ys_tvalid;
  logic                         point_strobe;
  logic [NPTS_W-1:0]            point_idx;
  logic [NPTS_W-1:0]            line_idx;
  logic                         dir;

  modport master (
    output M_AXIS_Xs_tdata, M_AXIS_Xs_tvalid,
    output M_AXIS_Ys_tdata, M_AXIS_Ys_tvalid,
    output point_strobe, point_idx, line_idx, dir
  );

  modport slave (
    input M_AXIS_Xs_tdata, M_AXIS_Xs_tvalid,
    input M_AXIS_Ys_tdata, M_AXIS_Ys_tvalid,
    input point_strobe, point_idx, line_idx, dir
  );
endinterface

// File: rtl/axis_scan_raster_gen_accum.sv
// One saturating Q31 coordinate register: load wins over inc, inc over dec.
module spm_sat_accum
  import spm_scan_pkg::*;
(
  input  logic                  a_clk,
  input  logic                  a_resetn,
  input  logic                  load,
  input  logic                  inc,
  input  logic                  dec,
  input  logic signed [Q_W-1:0] load_val,
  input  logic signed [Q_W-1:0] step,
  output logic signed [Q_W-1:0] value
);

  logic signed [Q_W-1:0] value_reg;

  // Coordinate register; it only returns to zero through reset.
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (inc) begin
      value_reg <= sat_add(value_reg, step, 1'b0);
    end else if (dec) begin
      value_reg <= sat_add(value_reg, step, 1'b1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/axis_scan_raster_gen.sv
// Raster scan generator: steps an nx x ny grid with per-point dwell and
// drives the relative Xs/Ys coordinate streams.
// Build option: define SCAN_BIDIR_EN for a backward pass on every line.
module axis_scan_raster_gen
  import spm_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NPTS_W     = 16,
  parameter int DWELL_W    = 24
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic                         start,
  input  logic                         abort,
  input  logic signed [DATA_WIDTH-1:0] x_start,
  input  logic signed [DATA_WIDTH-1:0] y_start,
  input  logic signed [DATA_WIDTH-1:0] dx,
  input  logic signed [DATA_WIDTH-1:0] dy,
  input  logic [NPTS_W-1:0]            nx,
  input  logic [NPTS_W-1:0]            ny,
  input  logic [DWELL_W-1:0]           dwell,
  output logic                         busy,
  output logic                         done,
  axis_scan_raster_gen_if.master       m_axis
);

  scan_state_e state_reg, state_next;

  // Shadow copies of the configuration, captured on an accepted start.
  // y_start is only needed on the start cycle itself, so it is not kept.
  logic signed [DATA_WIDTH-1:0] x_start_reg, x_start_next;
  logic signed [DATA_WIDTH-1:0] dx_reg, dx_next;
  logic signed [DATA_WIDTH-1:0] dy_reg, dy_next;
  logic [NPTS_W-1:0]            nx_reg, nx_next;
  logic [NPTS_W-1:0]            ny_reg, ny_next;
  logic [DWELL_W-1:0]           dwell_reg, dwell_next;

  logic [DWELL_W-1:0]           dwell_cnt_reg, dwell_cnt_next;
  logic [NPTS_W-1:0]            point_idx_reg, point_idx_next;
  logic [NPTS_W-1:0]            line_idx_reg, line_idx_next;
  logic                         strobe_reg, strobe_next;
  logic                         done_reg, done_next;
  logic                         tvalid_reg;
`ifdef SCAN_BIDIR_EN
  logic                         dir_reg, dir_next;
`endif

  // Index 0 is X, index 1 is Y.
  logic [1:0]            acc_load, acc_inc, acc_dec;
  logic signed [Q_W-1:0] acc_load_val [2];
  logic signed [Q_W-1:0] acc_step [2];
  logic signed [Q_W-1:0] acc_value [2];

  // Dwell counter reload: the point is held (count + 1) cycles, dwell 0 acts as 1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign acc_step[0] = dx_reg;
  assign acc_step[1] = dy_reg;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_accum
    spm_sat_accum u_accum (
      .a_clk    (a_clk),
      .a_resetn (a_resetn),
      .load     (acc_load[gi]),
      .inc      (acc_inc[gi]),
      .dec      (acc_dec[gi]),
      .load_val (acc_load_val[gi]),
      .step     (acc_step[gi]),
      .value    (acc_value[gi])
    );
  end

  // State and control registers.
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      state_reg     <= ST_IDLE;
      x_start_reg   <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      nx_reg        <= '0;
      ny_reg        <= '0;
      dwell_reg     <= '0;
      dwell_cnt_reg <= '0;
      point_idx_reg <= '0;
      line_idx_reg  <= '0;
      strobe_reg    <= 1'b0;
      done_reg      <= 1'b0;
      tvalid_reg    <= 1'b0;
`ifdef SCAN_BIDIR_EN
      dir_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      x_start_reg   <= x_start_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      nx_reg        <= nx_next;
      ny_reg        <= ny_next;
      dwell_reg     <= dwell_next;
      dwell_cnt_reg <= dwell_cnt_next;
      point_idx_reg <= point_idx_next;
      line_idx_reg  <= line_idx_next;
      strobe_reg    <= strobe_next;
      done_reg      <= done_next;
      tvalid_reg    <= 1'b1;
`ifdef SCAN_BIDIR_EN
      dir_reg       <= dir_next;
`endif
    end
  end

  // Next-state logic and coordinate update commands.
  always_comb begin
    state_next      = state_reg;
    x_start_next    = x_start_reg;
    dx_next         = dx_reg;
    dy_next         = dy_reg;
    nx_next         = nx_reg;
    ny_next         = ny_reg;
    dwell_next      = dwell_reg;
    dwell_cnt_next  = dwell_cnt_reg;
    point_idx_next  = point_idx_reg;
    line_idx_next   = line_idx_reg;
    strobe_next     = 1'b0;
    done_next       = 1'b0;
`ifdef SCAN_BIDIR_EN
    dir_next        = dir_reg;
`endif
    acc_load        = 2'b00;
    acc_inc         = 2'b00;
    acc_dec         = 2'b00;
    acc_load_val[0] = x_start_reg;
    acc_load_val[1] = y_start;

    if (abort) begin
      // Abort beats everything, including a same-cycle start in IDLE.
      state_next = ST_IDLE;
      done_next  = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            x_start_next = x_start;
            dx_next      = dx;
            dy_next      = dy;
            nx_next      = nx;
            ny_next      = ny;
            dwell_next   = dwell;
            if (nx == '0 || ny == '0) begin
              // Empty grid: finish without touching the coordinates.
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              state_next      = ST_FWD;
              acc_load        = 2'b11;
              acc_load_val[0] = x_start;
              acc_load_val[1] = y_start;
              point_idx_next  = '0;
              line_idx_next   = '0;
              strobe_next     = 1'b1;
              dwell_cnt_next  = dwell_reload(dwell);
`ifdef SCAN_BIDIR_EN
              dir_next        = 1'b0;
`endif
            end
          end
        end

        ST_FWD: begin
          if (dwell_cnt_reg != '0) begin
            dwell_cnt_next = dwell_cnt_reg - 1'b1;
          end else if (point_idx_reg != nx_reg - 1'b1) begin
            acc_inc[0]     = 1'b1;
            point_idx_next = point_idx_reg + 1'b1;
            strobe_next    = 1'b1;
            dwell_cnt_next = dwell_reload(dwell_reg);
          end else begin
`ifdef SCAN_BIDIR_EN
            // Backward pass starts by repeating the last forward X.
            state_next     = ST_BWD;
            dir_next       = 1'b1;
            strobe_next    = 1'b1;
            dwell_cnt_next = dwell_reload(dwell_reg);
`else
            state_next     = ST_NEXT_LINE;
`endif
          end
        end

`ifdef SCAN_BIDIR_EN
        ST_BWD: begin
          if (dwell_cnt_reg != '0) begin
            dwell_cnt_next = dwell_cnt_reg - 1'b1;
          end else if (point_idx_reg != '0) begin
            acc_dec[0]     = 1'b1;
            point_idx_next = point_idx_reg - 1'b1;
            strobe_next    = 1'b1;
            dwell_cnt_next = dwell_reload(dwell_reg);
          end else begin
            state_next = ST_NEXT_LINE;
          end
        end
`endif

        ST_NEXT_LINE: begin
          if (line_idx_reg == ny_reg - 1'b1) begin
            // Last line: no retrace, coordinates stay on the final point.
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next      = ST_FWD;
            acc_load[0]     = 1'b1;
            acc_load_val[0] = x_start_reg;
            acc_inc[1]      = 1'b1;
            line_idx_next   = line_idx_reg + 1'b1;
            point_idx_next  = '0;
            strobe_next     = 1'b1;
            dwell_cnt_next  = dwell_reload(dwell_reg);
`ifdef SCAN_BIDIR_EN
            dir_next        = 1'b0;
`endif
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == ST_FWD) || (state_reg == ST_BWD) || (state_reg == ST_NEXT_LINE);
  assign done = done_reg;

  assign m_axis.M_AXIS_Xs_tdata  = acc_value[0];
  assign m_axis.M_AXIS_Ys_tdata  = acc_value[1];
  assign m_axis.M_AXIS_Xs_tvalid = tvalid_reg;
  assign m_axis.M_AXIS_Ys_tvalid = tvalid_reg;
  assign m_axis.point_strobe     = strobe_reg;
  assign m_axis.point_idx        = point_idx_reg;
  assign m_axis.line_idx         = line_idx_reg;
`ifdef SCAN_BIDIR_EN
  assign m_axis.dir              = dir_reg;
`else
  assign m_axis.dir              = 1'b0;
`endif

endmodule
